// File: rtl/pulse_stretch_driver_pkg.sv
// Shared definitions for the pulse stretch driver and its cycle timer.
//   pulse_state_t  : FSM state encodings (IDLE=0, ON=1, GAP=2), also used by the debouncer
//   CYCLES_PER_MS  : cycles per millisecond at the 100 MHz system clock
//   max_u          : larger of two unsigned values
//   timer_width    : timer width able to reach the longer of the on/off windows
package pulse_stretch_driver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } pulse_state_t;

    localparam int unsigned CYCLES_PER_MS = 100_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned timer_width(input int unsigned on_cycles,
                                                input int unsigned off_cycles);
        return $clog2(max_u(on_cycles, off_cycles) + 1);
    endfunction

endpackage

// File: rtl/pulse_stretch_driver_timer.sv
// cycle_timer: up-counter with synchronous clear and a terminal-count flag.
//   clock   : system clock
//   reset   : asynchronous, active-low reset (count returns to zero)
//   clear   : synchronous clear, takes priority over counting
//   enable  : advance the count by one per cycle
//   limit   : terminal count value; done is high while count == limit
//   done    : terminal-count flag
// The count stops at limit instead of wrapping, so a stalled clear can never
// alias into a false terminal count later.
module cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] count;

    assign done = (count == limit);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !done) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pulse_stretch_driver.sv
// pulse_stretch_driver: turns single-cycle event strobes into indicator
// windows with a guaranteed on-time followed by a guaranteed off-gap.
// Events arriving while a window is running are queued and replayed
// back-to-back.
//   clock         : 100 MHz system clock
//   reset         : asynchronous, active-low reset; discards queued events
//   pulseIn       : event strobe, each high cycle is one event
//   ledOut        : registered pin drive, high during the on-window
//   busy          : high whenever a window (on or gap) is running
//   pendingCount  : events accepted but not yet started (saturating)
//   overflow      : one-cycle pulse when an event is dropped at saturation
module pulse_stretch_driver
    import pulse_stretch_driver_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 20 * CYCLES_PER_MS,
    parameter int unsigned OFF_CYCLES = 20 * CYCLES_PER_MS,
    parameter int unsigned PENDING_W  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pulseIn,
    output logic                 ledOut,
    output logic                 busy,
    output logic [PENDING_W-1:0] pendingCount,
    output logic                 overflow
);

    localparam int unsigned          TIMER_W     = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TIMER_W-1:0]   ON_LAST     = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   OFF_LAST    = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [PENDING_W-1:0] PENDING_MAX = '1;

    pulse_state_t       state;
    logic               timer_clear;
    logic               timer_enable;
    logic               timer_done;
    logic [TIMER_W-1:0] timer_limit;
    logic               last_gap;
    logic               queue_pulse;
    logic               queue_full;

    // The timer runs 0..limit inside each window; it is held at zero in IDLE
    // and cleared on every terminal count so the next window starts at zero.
    always_comb begin
        timer_limit  = (state == GAP) ? OFF_LAST : ON_LAST;
        timer_enable = (state != IDLE);
        timer_clear  = (state == IDLE) || timer_done;
        last_gap     = (state == GAP) && timer_done;
        // Pulses on the final gap cycle are handled by the restart logic,
        // never by the queue.
        queue_pulse  = pulseIn && ((state == ON) || ((state == GAP) && !timer_done));
        queue_full   = (pendingCount == PENDING_MAX);
    end

    cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .limit  (timer_limit),
        .done   (timer_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ledOut       <= 1'b0;
            busy         <= 1'b0;
            pendingCount <= '0;
            overflow     <= 1'b0;
        end else begin
            overflow <= 1'b0;

            if (queue_pulse) begin
                if (queue_full) begin
                    overflow <= 1'b1;
                end else begin
                    pendingCount <= pendingCount + PENDING_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (pulseIn) begin
                        state  <= ON;
                        ledOut <= 1'b1;
                        busy   <= 1'b1;
                    end
                end

                ON: begin
                    if (timer_done) begin
                        state  <= GAP;
                        ledOut <= 1'b0;
                    end
                end

                GAP: begin
                    if (last_gap) begin
                        if (pendingCount != '0) begin
                            // Queued event starts now; a coincident pulse
                            // takes its slot, so the count nets out unchanged.
                            state  <= ON;
                            ledOut <= 1'b1;
                            if (!pulseIn) begin
                                pendingCount <= pendingCount - PENDING_W'(1);
                            end
                        end else if (pulseIn) begin
                            state  <= ON;
                            ledOut <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    ledOut <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretch_driver.sv
// Self-checking bench for pulse_stretch_driver (ON=4, OFF=3, PENDING_W=2).
// A schedule model assigns each accepted event a window start cycle and
// derives every output from that schedule; directed literal checks pin it.
module tb_pulse_stretch_driver;

    localparam int ON_C  = 4;
    localparam int OFF_C = 3;
    localparam int PW    = 2;
    localparam int PER   = ON_C + OFF_C;
    localparam int PMAX  = (1 << PW) - 1;

    logic          clock;
    logic          reset;
    logic          pulseIn;
    logic          ledOut;
    logic          busy;
    logic [PW-1:0] pendingCount;
    logic          overflow;

    int compared   = 0;
    int mismatched = 0;

    pulse_stretch_driver #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .PENDING_W  (PW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pulseIn      (pulseIn),
        .ledOut       (ledOut),
        .busy         (busy),
        .pendingCount (pendingCount),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- schedule model ----------------
    int cyc = 0;
    int starts[$];
    int accs[$];
    int ovf_cyc = -1;

    function automatic logic m_led(input int c);
        foreach (starts[i]) if (starts[i] <= c && c < starts[i] + ON_C) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_busy(input int c);
        foreach (starts[i]) if (starts[i] <= c && c < starts[i] + PER) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_pend(input int c);
        int n = 0;
        foreach (starts[i]) if (accs[i] < c && starts[i] > c) n++;
        return n;
    endfunction

    // Event seen in cycle t: it starts at t+1 or right after the last scheduled
    // window, whichever is later; it is dropped if it would have to wait and
    // the waiting queue after this edge is already full.
    task automatic model_event(input int t);
        int endc = 0;
        int waiting = 0;
        int nw;
        foreach (starts[i]) begin
            if (starts[i] + PER > endc) endc = starts[i] + PER;
            if (starts[i] > t + 1) waiting++;
        end
        nw = (endc > t + 1) ? endc : t + 1;
        if (nw > t + 1 && waiting == PMAX) begin
            ovf_cyc = t + 1;
        end else begin
            starts.push_back(nw);
            accs.push_back(t);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                starts.delete();
                accs.delete();
                ovf_cyc = -1;
            end else if (clock) begin
                if (pulseIn) model_event(cyc);
                cyc++;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            chk("model_led",      32'(ledOut),       32'(m_led(cyc)));
            chk("model_busy",     32'(busy),         32'(m_busy(cyc)));
            chk("model_pending",  32'(pendingCount), 32'(m_pend(cyc)));
            chk("model_overflow", 32'(overflow),     32'(cyc == ovf_cyc));
        end
    end

    // ---------------- stimulus ----------------
    // Drive pulseIn for the current cycle, then advance to 1 time unit after
    // the next rising edge.
    task automatic tick(input logic p);
        pulseIn = p;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        pulseIn = 1'b0;

        // 1. reset held with pulseIn toggling
        for (int i = 0; i < 5; i++) begin
            tick(1'(i % 2));
            chk("rst_led",     32'(ledOut),       0);
            chk("rst_busy",    32'(busy),         0);
            chk("rst_pending", 32'(pendingCount), 0);
            chk("rst_ovf",     32'(overflow),     0);
        end
        pulseIn = 1'b0;
        reset   = 1'b1;
        idle_ticks(2);
        chk("post_rst_busy", 32'(busy), 0);

        // 2. single pulse: t0 pulse, on t1..t4, gap t5..t7, idle t8
        tick(1'b1);                       // now t1
        chk("t2_led_t1",  32'(ledOut), 1);
        chk("t2_busy_t1", 32'(busy),   1);
        idle_ticks(3);                    // t4
        chk("t2_led_t4",  32'(ledOut), 1);
        tick(1'b0);                       // t5
        chk("t2_led_t5",  32'(ledOut), 0);
        chk("t2_busy_t5", 32'(busy),   1);
        idle_ticks(2);                    // t7
        chk("t2_busy_t7", 32'(busy),   1);
        tick(1'b0);                       // t8
        chk("t2_busy_t8", 32'(busy),   0);
        idle_ticks(3);

        // 3. pulses at t0 and t1
        tick(1'b1);                       // t1
        tick(1'b1);                       // t2
        chk("t3_pend_t2", 32'(pendingCount), 1);
        idle_ticks(6);                    // t8
        chk("t3_led_t8",  32'(ledOut),       1);
        chk("t3_pend_t8", 32'(pendingCount), 0);
        idle_ticks(3);                    // t11
        chk("t3_led_t11", 32'(ledOut), 1);
        idle_ticks(3);                    // t14
        chk("t3_busy_t14", 32'(busy), 1);
        tick(1'b0);                       // t15
        chk("t3_busy_t15", 32'(busy), 0);
        idle_ticks(3);

        // 4. pulse at t0, four more during ON -> saturation on the fourth
        tick(1'b1);                       // t1
        tick(1'b1);                       // t2
        chk("t4_pend_t2", 32'(pendingCount), 1);
        tick(1'b1);                       // t3
        chk("t4_pend_t3", 32'(pendingCount), 2);
        tick(1'b1);                       // t4
        chk("t4_pend_t4", 32'(pendingCount), 3);
        chk("t4_ovf_t4",  32'(overflow),     0);
        tick(1'b1);                       // t5
        chk("t4_pend_t5", 32'(pendingCount), 3);
        chk("t4_ovf_t5",  32'(overflow),     1);
        tick(1'b0);                       // t6
        chk("t4_ovf_t6",  32'(overflow),     0);
        idle_ticks(2);                    // t8: second window
        chk("t4_led_t8",  32'(ledOut),       1);
        chk("t4_pend_t8", 32'(pendingCount), 2);
        idle_ticks(14);                   // t22: fourth window
        chk("t4_led_t22",  32'(ledOut),       1);
        chk("t4_pend_t22", 32'(pendingCount), 0);
        idle_ticks(6);                    // t28
        chk("t4_busy_t28", 32'(busy), 1);
        tick(1'b0);                       // t29
        chk("t4_busy_t29", 32'(busy), 0);
        idle_ticks(3);

        // 5. second pulse on the last gap cycle
        tick(1'b1);                       // t1
        idle_ticks(6);                    // t7
        tick(1'b1);                       // t8
        chk("t5_led_t8",  32'(ledOut),       1);
        chk("t5_busy_t8", 32'(busy),         1);
        chk("t5_pend_t8", 32'(pendingCount), 0);
        idle_ticks(10);
        chk("t5_busy_end", 32'(busy), 0);

        // 6. async reset with two queued events mid-ON
        tick(1'b1);                       // t1
        tick(1'b1);                       // t2
        tick(1'b1);                       // t3
        pulseIn = 1'b0;
        chk("t6_pend_pre", 32'(pendingCount), 2);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_led_async",  32'(ledOut),       0);
        chk("t6_pend_async", 32'(pendingCount), 0);
        chk("t6_busy_async", 32'(busy),         0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle_ticks(12);
        chk("t6_led_idle",  32'(ledOut), 0);
        chk("t6_busy_idle", 32'(busy),   0);
        tick(1'b1);
        chk("t6_led_new", 32'(ledOut), 1);
        idle_ticks(10);

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
